// File: rtl/mpsoc_wb2ahb3_bridge.sv
// Wishbone classic slave to AHB3-Lite master bridge.
// Each WB cycle becomes one AHB3 SINGLE transfer. Byte enables select HSIZE
// and the low address bits. At most one AHB transfer is outstanding.
module mpsoc_wb2ahb3_bridge #(
  parameter int          PLEN      = 64,
  parameter int          XLEN      = 64,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic              HRESETn,
  input  logic              HCLK,
  // Wishbone slave
  input  logic [PLEN-1:0]   wb_adr_i,
  input  logic [XLEN-1:0]   wb_dat_i,
  input  logic [XLEN/8-1:0] wb_sel_i,
  input  logic              wb_we_i,
  input  logic [2:0]        wb_cti_i,
  input  logic [1:0]        wb_bte_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic [XLEN-1:0]   wb_dat_o,
  // AHB3-Lite master
  output logic              HSEL,
  output logic [PLEN-1:0]   HADDR,
  output logic [XLEN-1:0]   HWDATA,
  input  logic [XLEN-1:0]   HRDATA,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [1:0]        HTRANS,
  output logic              HMASTLOCK,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam int SW  = XLEN / 8;
  localparam int LSB = $clog2(SW);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t         state_q;
  logic           abort_q;
  logic           legal_d;
  logic [2:0]     size_d;
  logic [LSB-1:0] off_d;
  logic           req;

  // cti/bte are irrelevant: every access is issued as a SINGLE
  logic unused_ok;
  assign unused_ok = ^{wb_cti_i, wb_bte_i};

  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;
  assign req       = wb_cyc_i & wb_stb_i;

  // Byte-enable decode: offset of lowest set bit, then match an aligned run
  always_comb begin
    legal_d = 1'b0;
    size_d  = 3'd0;
    off_d   = '0;
    for (int i = SW - 1; i >= 0; i--)
      if (wb_sel_i[i]) off_d = LSB'(i);
    if (wb_sel_i == (SW'(1) << off_d)) begin
      legal_d = 1'b1;
      size_d  = 3'd0;
    end else if (!off_d[0] && wb_sel_i == (SW'(3) << off_d)) begin
      legal_d = 1'b1;
      size_d  = 3'd1;
    end else if (off_d[1:0] == 2'b00 && wb_sel_i == (SW'(15) << off_d)) begin
      legal_d = 1'b1;
      size_d  = 3'd2;
    end else if (SW == 8 && &wb_sel_i) begin
      legal_d = 1'b1;
      size_d  = 3'd3;
    end
  end

  // Bridge FSM; all bus-facing outputs are registered here
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      abort_q  <= 1'b0;
      HTRANS   <= TR_IDLE;
      HSEL     <= 1'b0;
      HADDR    <= '0;
      HWDATA   <= '0;
      HWRITE   <= 1'b0;
      HSIZE    <= 3'd0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            if (legal_d) begin
              state_q <= S_ADDR;
              abort_q <= 1'b0;
              HTRANS  <= TR_NONSEQ;
              HSEL    <= 1'b1;
              HADDR   <= {wb_adr_i[PLEN-1:LSB], off_d};
              HSIZE   <= size_d;
              HWRITE  <= wb_we_i;
              HWDATA  <= wb_dat_i;
            end else begin
              // illegal byte enables never reach the AHB side
              state_q  <= S_RESP;
              wb_err_o <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (!req) abort_q <= 1'b1;
          if (HREADY) begin
            state_q <= S_DATA;
            HTRANS  <= TR_IDLE;
            HSEL    <= 1'b0;
          end
        end
        S_DATA: begin
          if (!req) abort_q <= 1'b1;
          if (HREADY) begin
            state_q <= S_RESP;
            if (!HWRITE) wb_dat_o <= HRDATA;
            // an abandoned WB cycle still completes on AHB but is not terminated
            if (!abort_q && req) begin
              wb_ack_o <= ~HRESP;
              wb_err_o <= HRESP;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpsoc_wb2ahb3_bridge.sv
// Directed bench for mpsoc_wb2ahb3_bridge (PLEN=64, XLEN=64).
module tb_mpsoc_wb2ahb3_bridge;

  logic        HRESETn, HCLK;
  logic [63:0] wb_adr_i, wb_dat_i;
  logic [7:0]  wb_sel_i;
  logic        wb_we_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic        wb_cyc_i, wb_stb_i;
  logic        wb_ack_o, wb_err_o;
  logic [63:0] wb_dat_o;
  logic        HSEL;
  logic [63:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK, HREADY, HRESP;

  int checks = 0;
  int errors = 0;

  mpsoc_wb2ahb3_bridge #(.PLEN(64), .XLEN(64), .HPROT_VAL(4'b0011)) dut (
    .HRESETn(HRESETn), .HCLK(HCLK),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_dat_o(wb_dat_o),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance past the next rising edge; outputs are sampled 1ns after it
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic req(input logic [63:0] adr, input logic [7:0] sel,
                     input logic we, input logic [63:0] dat);
    wb_adr_i = adr; wb_sel_i = sel; wb_we_i = we; wb_dat_i = dat;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
  endtask

  task automatic idle_wb();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  initial begin
    HRESETn = 1'b0; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
    wb_cti_i = 3'b111; wb_bte_i = 2'b01; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_htrans", 64'(HTRANS), 64'd0);
    chk("rst_hsel",   64'(HSEL), 64'd0);
    chk("rst_ack_err", 64'({wb_ack_o, wb_err_o}), 64'd0);
    chk("rst_haddr",  HADDR, 64'd0);
    chk("consts", 64'({HBURST, HPROT, HMASTLOCK}), 64'({3'b000, 4'b0011, 1'b0}));
    HRESETn = 1'b1;
    tick();

    // 1: dword write, zero wait
    req(64'h40, 8'hFF, 1'b1, 64'h1122334455667788);
    tick();
    chk("t1_htrans", 64'(HTRANS), 64'h2);
    chk("t1_hsel",   64'(HSEL), 64'd1);
    chk("t1_haddr",  HADDR, 64'h40);
    chk("t1_hsize",  64'(HSIZE), 64'd3);
    chk("t1_hwrite", 64'(HWRITE), 64'd1);
    tick();
    chk("t1_htrans_d", 64'(HTRANS), 64'h0);
    chk("t1_hwdata", HWDATA, 64'h1122334455667788);
    chk("t1_ack_early", 64'(wb_ack_o), 64'd0);
    tick();
    chk("t1_ack", 64'({wb_ack_o, wb_err_o}), 64'b10);
    idle_wb();
    tick();
    chk("t1_ack_off", 64'(wb_ack_o), 64'd0);

    // 2: half-word read at lanes 4..5
    HRDATA = 64'hAABBCCDD00000000;
    req(64'h40, 8'h30, 1'b0, 64'h0);
    tick();
    chk("t2_haddr", HADDR, 64'h44);
    chk("t2_hsize", 64'(HSIZE), 64'd1);
    chk("t2_hwrite", 64'(HWRITE), 64'd0);
    tick();
    tick();
    chk("t2_ack", 64'({wb_ack_o, wb_err_o}), 64'b10);
    chk("t2_rdata", wb_dat_o, 64'hAABBCCDD00000000);
    idle_wb();
    tick();
    chk("t2_ack_once", 64'(wb_ack_o), 64'd0);

    // 3: illegal byte enables
    req(64'h80, 8'h05, 1'b0, 64'h0);
    tick();
    chk("t3_err", 64'({wb_ack_o, wb_err_o}), 64'b01);
    chk("t3_htrans", 64'(HTRANS), 64'd0);
    idle_wb();
    tick();
    chk("t3_err_off", 64'(wb_err_o), 64'd0);
    chk("t3_htrans2", 64'(HTRANS), 64'd0);

    // 4: wait states, 2 in address phase, 3 in data phase
    req(64'h80, 8'h0F, 1'b1, 64'hDEADBEEFCAFEF00D);
    tick();                                     // cycle 1
    chk("t4_haddr", HADDR, 64'h80);
    chk("t4_hsize", 64'(HSIZE), 64'd2);
    HREADY = 1'b0;
    tick();                                     // cycle 2
    chk("t4_hold_c2", 64'({HTRANS, HSEL, HSIZE, HWRITE}), 64'({2'b10, 1'b1, 3'd2, 1'b1}));
    tick();                                     // cycle 3
    chk("t4_hold_c3", HADDR, 64'h80);
    chk("t4_htrans_c3", 64'(HTRANS), 64'h2);
    HREADY = 1'b1;
    tick();                                     // cycle 4: data phase
    chk("t4_data_htrans", 64'(HTRANS), 64'h0);
    HREADY = 1'b0;
    tick(); tick(); tick();                     // cycles 5..7
    chk("t4_no_ack_c7", 64'({wb_ack_o, wb_err_o}), 64'b00);
    HREADY = 1'b1;
    tick();                                     // cycle 8
    chk("t4_ack_c8", 64'({wb_ack_o, wb_err_o}), 64'b10);
    idle_wb();
    tick();

    // 5: two-cycle AHB ERROR response
    HRDATA = 64'h0;
    req(64'h100, 8'h01, 1'b0, 64'h0);
    tick();
    chk("t5_haddr", HADDR, 64'h100);
    chk("t5_hsize", 64'(HSIZE), 64'd0);
    tick();                                     // data phase
    HRESP = 1'b1; HREADY = 1'b0;
    tick();
    chk("t5_wait", 64'({wb_ack_o, wb_err_o}), 64'b00);
    HREADY = 1'b1;
    tick();
    chk("t5_err", 64'({wb_ack_o, wb_err_o}), 64'b01);
    HRESP = 1'b0;
    idle_wb();
    tick();
    chk("t5_err_off", 64'(wb_err_o), 64'd0);

    // 6a: asynchronous reset during data phase
    HRDATA = 64'h5555AAAA5555AAAA;
    req(64'h200, 8'h01, 1'b0, 64'h0);
    tick();
    tick();                                     // data phase
    HREADY = 1'b0;
    tick();                                     // still in data phase
    HRESETn = 1'b0;
    #1;
    chk("t6_rst_bus", 64'({HTRANS, HSEL, HWRITE, HSIZE}), 64'd0);
    chk("t6_rst_haddr", HADDR, 64'd0);
    chk("t6_rst_wb", 64'({wb_ack_o, wb_err_o}), 64'd0);
    chk("t6_rst_dat", wb_dat_o, 64'd0);
    HRESETn = 1'b1; HREADY = 1'b1;
    idle_wb();
    tick();
    chk("t6_after_rst", 64'({wb_ack_o, wb_err_o, HTRANS}), 64'd0);

    // 6b: WB cycle dropped during address phase
    HRDATA = 64'h0123456789ABCDEF;
    req(64'h200, 8'hC0, 1'b0, 64'h0);
    tick();
    chk("t6b_haddr", HADDR, 64'h206);
    chk("t6b_htrans", 64'(HTRANS), 64'h2);
    idle_wb();
    tick();                                     // data phase still runs
    chk("t6b_htrans_d", 64'(HTRANS), 64'h0);
    tick();                                     // resp cycle, silent
    chk("t6b_no_term", 64'({wb_ack_o, wb_err_o}), 64'b00);
    chk("t6b_rdata", wb_dat_o, 64'h0123456789ABCDEF);
    tick();
    chk("t6b_no_term2", 64'({wb_ack_o, wb_err_o}), 64'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
